// File: rtl/aes_round_sched_if.sv
// Handshake bundle between the AES round sequencer, its block source/sink and the shared round unit.
// The slave view is the sequencer; the master view is the environment driving it.
interface aes_round_sched_if;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned KIND_W = 2;

  // Block input side
  logic               in_valid;
  logic               in_ready;
  logic [BLK_W-1:0]   in_data;
  logic               encdec;
  logic               flush;

  // Round unit side
  logic               rnd_req;
  logic               rnd_ack;
  logic [BLK_W-1:0]   rnd_state;
  logic [IDX_W-1:0]   rnd_key_idx;
  logic [KIND_W-1:0]  rnd_kind;
  logic               rnd_dec;
  logic [BLK_W-1:0]   rnd_res;

  // Result output side
  logic               out_valid;
  logic               out_ready;
  logic [BLK_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, encdec, flush, rnd_ack, rnd_res, out_ready,
    input  in_ready, rnd_req, rnd_state, rnd_key_idx, rnd_kind, rnd_dec, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, encdec, flush, rnd_ack, rnd_res, out_ready,
    output in_ready, rnd_req, rnd_state, rnd_key_idx, rnd_kind, rnd_dec, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_sched.sv
// Round sequencer for the iterative AES datapath: accepts a block, walks the shared round
// unit through rounds 0..NR with the matching key index and round kind, then holds the result.
module aes_round_sched #(
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_sched_if.slave bus
);
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned KIND_W = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [CNT_W-1:0]  LAST_RND  = CNT_W'(NR);
  localparam logic [KIND_W-1:0] K_INIT    = 2'd0;
  localparam logic [KIND_W-1:0] K_FULL    = 2'd1;
  localparam logic [KIND_W-1:0] K_FINAL   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] data_q, data_d;
  // Holds the inverse-cipher flag (1 = decrypt) so that the reset value maps to key index 0.
  logic             dec_q, dec_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    dec_d           = dec_q;
    bus.in_ready    = 1'b0;
    bus.rnd_req     = 1'b0;
    bus.out_valid   = 1'b0;
    bus.rnd_state   = data_q;
    bus.out_data    = data_q;
    bus.rnd_dec     = dec_q;
    bus.rnd_key_idx = dec_q ? (LAST_RND - cnt_q) : cnt_q;
    bus.rnd_kind    = K_FULL;

    if (cnt_q == '0) begin
      bus.rnd_kind = K_INIT;
    end else if (cnt_q == LAST_RND) begin
      bus.rnd_kind = K_FINAL;
    end

    case (state_q)
      S_IDLE: begin
        // flush blocks acceptance in the same cycle
        bus.in_ready = ~bus.flush;
        if (!bus.flush && bus.in_valid) begin
          data_d  = bus.in_data;
          dec_d   = ~bus.encdec;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.rnd_req = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.rnd_ack) begin
          data_d = bus.rnd_res;
          if (cnt_q == LAST_RND) begin
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.flush || bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: behavioural AES round unit, transaction-level scoreboard and
// directed plus random scenarios covering latency, back-pressure, flush and reset.
module tb_aes_round_sched;
  localparam int unsigned NR = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_sched_if bus ();

  aes_round_sched #(.NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES reference ----------------
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk  [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv ? isb[gb(x, i)] : sb[gb(x, i)];
    return y;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    int src;
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        y[127-8*(r+4*c) -: 8] = gb(x, r + 4*src);
      end
    return y;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(x, 4*c); a1 = gb(x, 4*c+1); a2 = gb(x, 4*c+2); a3 = gb(x, 4*c+3);
      if (!inv) begin
        y[127-8*(4*c)   -: 8] = gm(a0,8'd2) ^ gm(a1,8'd3) ^ a2 ^ a3;
        y[127-8*(4*c+1) -: 8] = a0 ^ gm(a1,8'd2) ^ gm(a2,8'd3) ^ a3;
        y[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gm(a2,8'd2) ^ gm(a3,8'd3);
        y[127-8*(4*c+3) -: 8] = gm(a0,8'd3) ^ a1 ^ a2 ^ gm(a3,8'd2);
      end else begin
        y[127-8*(4*c)   -: 8] = gm(a0,8'd14) ^ gm(a1,8'd11) ^ gm(a2,8'd13) ^ gm(a3,8'd9);
        y[127-8*(4*c+1) -: 8] = gm(a0,8'd9)  ^ gm(a1,8'd14) ^ gm(a2,8'd11) ^ gm(a3,8'd13);
        y[127-8*(4*c+2) -: 8] = gm(a0,8'd13) ^ gm(a1,8'd9)  ^ gm(a2,8'd14) ^ gm(a3,8'd11);
        y[127-8*(4*c+3) -: 8] = gm(a0,8'd11) ^ gm(a1,8'd13) ^ gm(a2,8'd9)  ^ gm(a3,8'd14);
      end
    end
    return y;
  endfunction

  function automatic void build_tables();
    logic [7:0] x, inv, s;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      if (i != 0)
        for (int j = 1; j < 256; j++)
          if (gm(x, 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[i]  = s;
      isb[s] = x;
    end
  endfunction

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Whole-cipher reference used as the expected result of a block
  function automatic logic [127:0] aes_ref(input logic [127:0] x, input bit dec);
    logic [127:0] s;
    if (!dec) begin
      s = x ^ rk[0];
      for (int r = 1; r < 10; r++) s = mix_c(shift_r(sub_b(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
      s = shift_r(sub_b(s, 1'b0), 1'b0) ^ rk[10];
    end else begin
      s = x ^ rk[10];
      for (int r = 9; r >= 1; r--) s = mix_c(sub_b(shift_r(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
      s = sub_b(shift_r(s, 1'b1), 1'b1) ^ rk[0];
    end
    return s;
  endfunction

  // Single pass of the behavioural round unit
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [3:0] idx,
                                            input logic [1:0] kind, input bit dec);
    logic [127:0] k;
    k = (idx <= 4'd10) ? rk[idx] : '0;
    if (kind == 2'd0) return s ^ k;
    if (!dec) begin
      if (kind == 2'd1) return mix_c(shift_r(sub_b(s, 1'b0), 1'b0), 1'b0) ^ k;
      return shift_r(sub_b(s, 1'b0), 1'b0) ^ k;
    end
    if (kind == 2'd1) return mix_c(sub_b(shift_r(s, 1'b1), 1'b1) ^ k, 1'b1);
    return sub_b(shift_r(s, 1'b1), 1'b1) ^ k;
  endfunction

  // ---------------- round unit responder (drives at negedge) ----------------
  int max_dly   = 0;
  int flush_key = -1;
  bit pend      = 1'b0;
  int wcnt      = 0;

  initial begin
    bus.rnd_ack = 1'b0;
    bus.rnd_res = '0;
    bus.flush   = 1'b0;
    forever begin
      @(negedge clk);
      bus.flush   = 1'b0;
      bus.rnd_ack = 1'b0;
      if (!rst || !bus.rnd_req) begin
        pend = 1'b0;
      end else begin
        if (!pend) begin
          pend = 1'b1;
          wcnt = int'($urandom_range(max_dly, 0));
        end
        if (wcnt == 0) begin
          bus.rnd_ack = 1'b1;
          bus.rnd_res = round_fn(bus.rnd_state, bus.rnd_key_idx, bus.rnd_kind, bus.rnd_dec);
          pend = 1'b0;
          if (flush_key >= 0 && int'(bus.rnd_key_idx) == flush_key) begin
            bus.flush = 1'b1;
            flush_key = -1;
          end
        end else begin
          wcnt--;
        end
      end
    end
  end

  // ---------------- scoreboard (samples at negedge+2) ----------------
  bit           m_busy = 1'b0, m_hold = 1'b0, m_dec = 1'b0, ov_prev = 1'b0;
  int           m_round = 0;
  logic [127:0] m_state = '0, m_exp = '0;
  int           cyc = 0, acc_cnt = 0, out_cnt = 0, acc_cyc = 0, ouths_cyc = 0, ov_rise_cyc = 0;
  logic [127:0] got_q [$];
  int           key_log [$];
  int           kind_log [$];

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst) begin
        m_busy  = 1'b0;
        m_hold  = 1'b0;
        ov_prev = 1'b0;
      end else begin
        chk("in_ready", 128'(bus.in_ready), 128'(!m_busy && !m_hold && !bus.flush));
        chk("rnd_req", 128'(bus.rnd_req), 128'(m_busy));
        chk("out_valid", 128'(bus.out_valid), 128'(m_hold));
        if (m_busy) begin
          chk("rnd_state", bus.rnd_state, m_state);
          chk("rnd_key_idx", 128'(bus.rnd_key_idx), 128'(m_dec ? NR - m_round : m_round));
          chk("rnd_kind", 128'(bus.rnd_kind),
              128'((m_round == 0) ? 0 : (m_round == NR) ? 2 : 1));
          chk("rnd_dec", 128'(bus.rnd_dec), 128'(m_dec));
        end
        if (m_hold) chk("out_data", bus.out_data, m_exp);
        if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
        ov_prev = bus.out_valid;

        if (bus.flush && (m_busy || m_hold)) begin
          m_busy = 1'b0;
          m_hold = 1'b0;
        end else if (m_busy) begin
          if (bus.rnd_ack) begin
            key_log.push_back(int'(bus.rnd_key_idx));
            kind_log.push_back(int'(bus.rnd_kind));
            m_state = bus.rnd_res;
            if (m_round == NR) begin
              m_busy = 1'b0;
              m_hold = 1'b1;
            end else begin
              m_round++;
            end
          end
        end else if (m_hold) begin
          if (bus.out_ready) begin
            m_hold = 1'b0;
            got_q.push_back(bus.out_data);
            out_cnt++;
            ouths_cyc = cyc;
          end
        end else if (bus.in_valid && !bus.flush) begin
          m_busy  = 1'b1;
          m_round = 0;
          m_dec   = !bus.encdec;
          m_state = bus.in_data;
          m_exp   = aes_ref(bus.in_data, !bus.encdec);
          acc_cnt++;
          acc_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers (drive at negedge+1) ----------------
  task automatic send_block(input logic [127:0] data, input bit enc);
    int a0, t;
    a0 = acc_cnt;
    t  = 0;
    @(negedge clk); #1;
    bus.in_data  = data;
    bus.encdec   = enc;
    bus.in_valid = 1'b1;
    #2;
    while (acc_cnt == a0 && t < 200) begin
      @(negedge clk); #3;
      t++;
    end
    if (acc_cnt == a0) chk("accept_timeout", 128'(acc_cnt), 128'(a0 + 1));
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.encdec   = $urandom_range(1, 0) == 1;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(negedge clk); #1;
    while (!bus.out_valid && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 128'(bus.out_valid), 128'(1));
  endtask

  task automatic take_out(input int hold, output logic [127:0] res);
    int o0, t;
    o0 = out_cnt;
    t  = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #2;
    while (out_cnt == o0 && t < 500) begin
      @(negedge clk); #3;
      t++;
    end
    if (out_cnt == o0) chk("out_handshake_timeout", 128'(out_cnt), 128'(o0 + 1));
    @(negedge clk); #1;
    bus.out_ready = 1'b0;
    res = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
  endtask

  task automatic run_block(input logic [127:0] data, input bit enc, input int hold,
                           output logic [127:0] res);
    send_block(data, enc);
    wait_valid();
    take_out(hold, res);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    chk({tag, "_rnd_req"}, 128'(bus.rnd_req), 128'(0));
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_rnd_state"}, bus.rnd_state, 128'(0));
    chk({tag, "_out_data"}, bus.out_data, 128'(0));
    chk({tag, "_rnd_key_idx"}, 128'(bus.rnd_key_idx), 128'(0));
    chk({tag, "_rnd_kind"}, 128'(bus.rnd_kind), 128'(0));
    chk({tag, "_rnd_dec"}, 128'(bus.rnd_dec), 128'(0));
  endtask

  task automatic wait_key(input int k, input bit need_no_ack);
    int t;
    t = 0;
    @(negedge clk); #1;
    while (!(bus.rnd_req && int'(bus.rnd_key_idx) == k && !(need_no_ack && bus.rnd_ack))
           && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    chk("wait_key_found", 128'(bus.rnd_key_idx), 128'(k));
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] pt, ct, key, res, d;
  int o0;
  bit enc;

  initial begin
    pt  = 128'h00112233445566778899aabbccddeeff;
    ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.encdec    = 1'b0;
    bus.out_ready = 1'b0;
    build_tables();
    expand_key(key);

    // Pin the reference against FIPS-197 C.1 values
    chk("ref_sbox_00", 128'(sb[0]), 128'h63);
    chk("ref_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("ref_round0", round_fn(pt, 4'd0, 2'd0, 1'b0), 128'h00102030405060708090a0b0c0d0e0f0);
    chk("ref_enc", aes_ref(pt, 1'b0), ct);
    chk("ref_dec", aes_ref(ct, 1'b1), pt);

    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;

    // Encrypt, ack every cycle
    max_dly = 0;
    key_log.delete();
    kind_log.delete();
    run_block(pt, 1'b1, 0, res);
    chk("enc_out", res, ct);
    chk("enc_latency", 128'(ov_rise_cyc - acc_cyc), 128'(12));
    chk("enc_key_cnt", 128'(key_log.size()), 128'(11));
    for (int i = 0; i < key_log.size() && i < 11; i++) begin
      chk("enc_key_seq", 128'(key_log[i]), 128'(i));
      chk("enc_kind_seq", 128'(kind_log[i]), 128'((i == 0) ? 0 : (i == 10) ? 2 : 1));
    end

    // Decrypt
    key_log.delete();
    run_block(ct, 1'b0, 0, res);
    chk("dec_out", res, pt);
    chk("dec_key_cnt", 128'(key_log.size()), 128'(11));
    for (int i = 0; i < key_log.size() && i < 11; i++)
      chk("dec_key_seq", 128'(key_log[i]), 128'(10 - i));

    // Random ack delay
    max_dly = 5;
    run_block(pt, 1'b1, 0, res);
    chk("dly_enc_out", res, ct);

    // Back-pressure for 20 cycles, then immediate second block
    max_dly = 0;
    send_block(pt, 1'b1);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_out_data", bus.out_data, ct);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    o0 = acc_cnt;
    bus.in_data   = ct;
    bus.encdec    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk); #3;
    chk("bp_second_accepted", 128'(acc_cnt), 128'(o0 + 1));
    chk("bp_accept_gap", 128'(acc_cyc - ouths_cyc), 128'(1));
    chk("bp_first_result", got_q[got_q.size()-1], ct);
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid();
    take_out(0, res);
    chk("bp_second_out", res, pt);

    // Flush coincident with the round-5 ack
    o0 = out_cnt;
    flush_key = 5;
    send_block(pt, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    end
    chk("flush_fired", 128'(flush_key), 128'(-1));
    chk("flush_no_output", 128'(out_cnt), 128'(o0));
    key_log.delete();
    run_block(pt, 1'b1, 1, res);
    chk("after_flush_first_key", 128'(key_log.size() > 0 ? key_log[0] : -1), 128'(0));
    chk("after_flush_out", res, ct);

    // Reset at cnt=7, right after the falling clock edge
    max_dly = 2;
    o0 = out_cnt;
    send_block(pt, 1'b1);
    wait_key(7, 1'b0);
    rst = 1'b0;
    #1 check_reset_outputs("rstA");
    @(negedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
    end
    chk("rstA_no_output", 128'(out_cnt), 128'(o0));
    run_block(ct, 1'b0, 0, res);
    chk("rstA_fresh_out", res, pt);

    // Reset at cnt=7, just after a rising edge
    max_dly = 5;
    o0 = out_cnt;
    send_block(pt, 1'b1);
    wait_key(7, 1'b1);
    #6;
    rst = 1'b0;
    #1 check_reset_outputs("rstB");
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
    end
    chk("rstB_no_output", 128'(out_cnt), 128'(o0));
    run_block(pt, 1'b1, 0, res);
    chk("rstB_fresh_out", res, ct);

    // Random blocks, modes, delays and back-pressure
    for (int n = 0; n < 12; n++) begin
      d       = {$urandom, $urandom, $urandom, $urandom};
      enc     = $urandom_range(1, 0) == 1;
      max_dly = int'($urandom_range(3, 0));
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) @(negedge clk);
      run_block(d, enc, int'($urandom_range(4, 0)), res);
      chk("rand_out", res, aes_ref(d, !enc));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
